// File: rtl/mbist_ctrl.sv
// March C- memory BIST controller: drives one memory port, checks read data the
// cycle after each read and aborts with diagnostics on the first mismatch.
module mbist_ctrl #(
  parameter int word_size    = 8,
  parameter int address_bits = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    fail,
  output logic [0:address_bits-1] fail_add,
  output logic [0:2]              fail_elem,
  output logic [0:word_size-1]    fail_mask,
  output logic                    mem_enable,
  output logic                    mem_RW,
  output logic [0:address_bits-1] mem_add,
  output logic [0:word_size-1]    mem_data_w,
  input  logic [0:word_size-1]    mem_data_r
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CHECK,
    S_DONE
  } state_e;

  typedef logic [address_bits-1:0] addr_t;
  typedef logic [word_size-1:0]    word_t;
  typedef logic [2:0]              elem_t;

  localparam addr_t ADDR_FIRST = '0;
  localparam addr_t ADDR_LAST  = '1;
  localparam word_t WORD_P0    = '0;
  localparam word_t WORD_P1    = '1;

  localparam elem_t M0 = 3'd0;
  localparam elem_t M1 = 3'd1;
  localparam elem_t M2 = 3'd2;
  localparam elem_t M3 = 3'd3;
  localparam elem_t M4 = 3'd4;
  localparam elem_t M5 = 3'd5;

  state_e                    state_q;
  addr_t                     addr_q;
  elem_t                     elem_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      fail_q;
  logic [0:address_bits-1]   fail_add_q;
  logic [0:2]                fail_elem_q;
  logic [0:word_size-1]      fail_mask_q;

  word_t exp_word;
  word_t wr_word;
  logic  mismatch;
  logic  descending;
  logic  at_last;
  addr_t addr_step;
  addr_t next_first;
  logic  check_write;

  // Per-element decode: read expectation, write pattern and address direction.
  // NOTE: every signal gets a default at the top of always_comb so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    exp_word    = WORD_P0;
    wr_word     = WORD_P0;
    descending  = 1'b0;
    next_first  = ADDR_FIRST;
    if (elem_q == M2 || elem_q == M4) exp_word = WORD_P1;
    if (elem_q == M1 || elem_q == M3) wr_word  = WORD_P1;
    if (elem_q >= M3)                 descending = 1'b1;
    if (elem_q + elem_t'(1) >= M3)    next_first = ADDR_LAST;
    at_last     = descending ? (addr_q == ADDR_FIRST) : (addr_q == ADDR_LAST);
    addr_step   = descending ? (addr_q - addr_t'(1)) : (addr_q + addr_t'(1));
    mismatch    = (state_q == S_CHECK) && (mem_data_r != exp_word);
    check_write = (state_q == S_CHECK) && !mismatch && (elem_q != M5);
  end

  // NOTE: the CHECK-cycle write depends on read data that only arrives in that
  // same cycle, so the memory strobes are a decode of state rather than flops.
  assign mem_enable = (state_q == S_WRITE) || (state_q == S_READ) || check_write;
  assign mem_RW     = (state_q == S_WRITE) || check_write;
  assign mem_add    = addr_q;
  assign mem_data_w = check_write ? wr_word : WORD_P0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_add  = fail_add_q;
  assign fail_elem = fail_elem_q;
  assign fail_mask = fail_mask_q;

  // NOTE: state and results use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= ADDR_FIRST;
      elem_q      <= M0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_add_q  <= '0;
      fail_elem_q <= '0;
      fail_mask_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_WRITE;
            addr_q      <= ADDR_FIRST;
            elem_q      <= M0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_add_q  <= '0;
            fail_elem_q <= '0;
            fail_mask_q <= '0;
          end
        end
        S_WRITE: begin
          if (addr_q == ADDR_LAST) begin
            addr_q  <= ADDR_FIRST;
            elem_q  <= M1;
            state_q <= S_READ;
          end else begin
            addr_q <= addr_q + addr_t'(1);
          end
        end
        S_READ: begin
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_q      <= 1'b1;
            fail_add_q  <= addr_q;
            fail_elem_q <= elem_q;
            fail_mask_q <= mem_data_r ^ exp_word;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end else if (at_last) begin
            if (elem_q == M5) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              elem_q  <= elem_q + elem_t'(1);
              addr_q  <= next_first;
              state_q <= S_READ;
            end
          end else begin
            addr_q  <= addr_step;
            state_q <= S_READ;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
